// File: rtl/multi_edge_detector.sv
// Multi-channel input conditioner: synchroniser, optional debouncer, per-channel edge pulse and sticky flag.
// Define MULTI_EDGE_DETECTOR_DEBOUNCE_EN to build the debounce counters; otherwise level follows the synchroniser.
module multi_edge_detector #(
    parameter int   CHANNELS        = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 250000,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CHANNELS-1:0]   data,
    input  logic [2*CHANNELS-1:0] select_edge,
    input  logic [CHANNELS-1:0]   event_clr,
    output logic [CHANNELS-1:0]   pulso,
    output logic [CHANNELS-1:0]   event_flag,
    output logic [CHANNELS-1:0]   level
);

    typedef enum logic [1:0] {
        EDGE_FALL     = 2'b00,
        EDGE_RISE     = 2'b01,
        EDGE_BOTH     = 2'b10,
        EDGE_BOTH_ALT = 2'b11
    } edge_sel_e;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("multi_edge_detector: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_out;
        logic                   level_q;
        logic                   pulse_q;
        logic                   flag_q;
        logic                   change;
        logic                   edge_match;
        edge_sel_e              sel;

        assign sync_out = sync_q[SYNC_STAGES-1];
        assign sel      = edge_sel_e'(select_edge[2*i +: 2]);

        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
            else     sync_q <= {sync_q[SYNC_STAGES-2:0], data[i]};
        end

`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
        localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q;
        logic             differs;

        // Disabled channels count as "no difference", so a stalled debounce restarts from zero.
        assign differs = enable && (sync_out != level_q);
        assign change  = differs && (cnt_q == CNT_LAST);

        always_ff @(posedge clk) begin
            if (rst || !differs || change) cnt_q <= '0;
            else                           cnt_q <= cnt_q + 1'b1;
        end
`else
        assign change = enable && (sync_out != level_q);
`endif

        // NOTE: the default assignment ahead of the case keeps this block free of inferred latches.
        always_comb begin
            edge_match = 1'b0;
            case (sel)
                EDGE_FALL: edge_match = !sync_out;
                EDGE_RISE: edge_match = sync_out;
                default:   edge_match = 1'b1;
            endcase
        end

        // A new detection outranks a simultaneous clear so no event is lost.
        always_ff @(posedge clk) begin
            if (rst) begin
                level_q <= IDLE_LEVEL;
                pulse_q <= 1'b0;
                flag_q  <= 1'b0;
            end else begin
                if (change) level_q <= sync_out;
                pulse_q <= change && edge_match;
                if (change && edge_match) flag_q <= 1'b1;
                else if (event_clr[i])    flag_q <= 1'b0;
            end
        end

        assign level[i]      = level_q;
        assign pulso[i]      = pulse_q;
        assign event_flag[i] = flag_q;
    end

endmodule
